// File: rtl/dfd_tnif_sink.sv
// rtl/dfd_tnif_sink.sv - TNIF trace-link sink: beat FIFO, backpressure/flush control, beat counters
module dfd_tnif_sink #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int FIFO_ENTRIES        = 8,
    parameter int BP_THRESHOLD        = 2,
    parameter int QUIET_CYCLES        = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sink_enable_in,
    input  logic                             sw_flush_req_in,
    input  logic                             tr_vld_in,
    input  logic                             tr_src_in,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] tr_data_in,
    output logic                             tr_gnt_out,
    output logic                             dst_bp_out,
    output logic                             ntr_bp_out,
    output logic                             dst_flush_out,
    output logic                             ntr_flush_out,
    output logic                             sw_flush_done_out,
    output logic                             sink_vld_out,
    output logic                             sink_src_out,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] sink_data_out,
    input  logic                             sink_rdy_in,
    output logic [31:0]                      dst_beat_cnt_out,
    output logic [31:0]                      ntr_beat_cnt_out
);
    localparam int W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int PW = $clog2(FIFO_ENTRIES);
    localparam int CW = PW + 1;
    localparam int QW = $clog2(QUIET_CYCLES);

    localparam logic [CW-1:0] DEPTH      = CW'(FIFO_ENTRIES);
    localparam logic [CW-1:0] BP_TH      = CW'(BP_THRESHOLD);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          alive_q, alive_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic          bp_q, bp_d;
    logic          flush_q, flush_d;
    logic          done_q, done_d;
    logic [31:0]   dst_cnt_q, dst_cnt_d;
    logic [31:0]   ntr_cnt_q, ntr_cnt_d;
    logic [W:0]    mem_q [FIFO_ENTRIES];

    logic          gnt;
    logic          push;
    logic          pop;
    logic          empty;
    logic [W:0]    head;

    // Handshake decode: grant depends only on registers, so a pop never frees a slot for a same-cycle push
    always_comb begin
        empty = (count_q == '0);
        gnt   = alive_q && (state_q != S_STOP) && (count_q < DEPTH);
        push  = tr_vld_in && gnt;
        pop   = !empty && sink_rdy_in;
        head  = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Next-state logic for FIFO bookkeeping, beat counters, flush FSM and registered controls
    always_comb begin
        alive_d   = 1'b1;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        dst_cnt_d = dst_cnt_q;
        ntr_cnt_d = ntr_cnt_q;
        if (push && !tr_src_in && (dst_cnt_q != '1)) dst_cnt_d = dst_cnt_q + 32'd1;
        if (push &&  tr_src_in && (ntr_cnt_q != '1)) ntr_cnt_d = ntr_cnt_q + 32'd1;

        state_d = state_q;
        quiet_d = quiet_q;
        case (state_q)
            S_IDLE: begin
                if (!sink_enable_in) begin
                    state_d = S_STOP;
                end else if (sw_flush_req_in) begin
                    state_d = S_FLUSH;
                    quiet_d = '0;
                end
            end
            S_FLUSH: begin
                if (!sink_enable_in)            state_d = S_STOP;
                else if (push)                  quiet_d = '0;
                else if (quiet_q == QUIET_LAST) state_d = S_DRAIN;
                else                            quiet_d = quiet_q + QW'(1);
            end
            S_DRAIN: begin
                if (!sink_enable_in)      state_d = S_STOP;
                else if (count_d == '0)   state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_STOP:  if (sink_enable_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        flush_d = (state_d == S_FLUSH) || (state_d == S_STOP);
        bp_d    = ((DEPTH - count_d) <= BP_TH) || (state_d == S_STOP);
        done_d  = (state_d == S_DONE);
    end

    // Control, pointer and counter registers; reset discards any queued beats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            alive_q   <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            quiet_q   <= '0;
            bp_q      <= 1'b0;
            flush_q   <= 1'b0;
            done_q    <= 1'b0;
            dst_cnt_q <= '0;
            ntr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            alive_q   <= alive_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            quiet_q   <= quiet_d;
            bp_q      <= bp_d;
            flush_q   <= flush_d;
            done_q    <= done_d;
            dst_cnt_q <= dst_cnt_d;
            ntr_cnt_q <= ntr_cnt_d;
        end
    end

    // Beat storage {src, data}; stale entries are masked by the empty check, so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {tr_src_in, tr_data_in};
    end

    assign tr_gnt_out        = gnt;
    assign dst_bp_out        = bp_q;
    assign ntr_bp_out        = bp_q;
    assign dst_flush_out     = flush_q;
    assign ntr_flush_out     = flush_q;
    assign sw_flush_done_out = done_q;
    assign sink_vld_out      = !empty;
    assign sink_src_out      = head[W];
    assign sink_data_out     = head[W-1:0];
    assign dst_beat_cnt_out  = dst_cnt_q;
    assign ntr_beat_cnt_out  = ntr_cnt_q;

endmodule

// File: tb/tb_dfd_tnif_sink.sv
// tb/tb_dfd_tnif_sink.sv - directed self-checking bench for dfd_tnif_sink
module tb_dfd_tnif_sink;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset;
    logic         sink_enable_in;
    logic         sw_flush_req_in;
    logic         tr_vld_in;
    logic         tr_src_in;
    logic [W-1:0] tr_data_in;
    logic         tr_gnt_out;
    logic         dst_bp_out;
    logic         ntr_bp_out;
    logic         dst_flush_out;
    logic         ntr_flush_out;
    logic         sw_flush_done_out;
    logic         sink_vld_out;
    logic         sink_src_out;
    logic [W-1:0] sink_data_out;
    logic         sink_rdy_in;
    logic [31:0]  dst_beat_cnt_out;
    logic [31:0]  ntr_beat_cnt_out;

    int checks = 0;
    int errors = 0;

    dfd_tnif_sink dut (
        .clk               (clk),
        .reset             (reset),
        .sink_enable_in    (sink_enable_in),
        .sw_flush_req_in   (sw_flush_req_in),
        .tr_vld_in         (tr_vld_in),
        .tr_src_in         (tr_src_in),
        .tr_data_in        (tr_data_in),
        .tr_gnt_out        (tr_gnt_out),
        .dst_bp_out        (dst_bp_out),
        .ntr_bp_out        (ntr_bp_out),
        .dst_flush_out     (dst_flush_out),
        .ntr_flush_out     (ntr_flush_out),
        .sw_flush_done_out (sw_flush_done_out),
        .sink_vld_out      (sink_vld_out),
        .sink_src_out      (sink_src_out),
        .sink_data_out     (sink_data_out),
        .sink_rdy_in       (sink_rdy_in),
        .dst_beat_cnt_out  (dst_beat_cnt_out),
        .ntr_beat_cnt_out  (ntr_beat_cnt_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sink_enable_in = 1'b1; sw_flush_req_in = 1'b0;
        tr_vld_in = 1'b0; tr_src_in = 1'b0; tr_data_in = '0; sink_rdy_in = 1'b0;
        tick(); tick();
        checks++; if (tr_gnt_out !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %0b exp 0", tr_gnt_out); end
        checks++; if ({dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out, sw_flush_done_out} !== 5'b0) begin
            errors++; $display("FAIL rst_ctrl: got %b exp 00000", {dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out, sw_flush_done_out}); end
        checks++; if ({sink_vld_out, sink_src_out} !== 2'b0 || sink_data_out !== '0) begin
            errors++; $display("FAIL rst_sink: got vld %0b src %0b data %0h exp 0", sink_vld_out, sink_src_out, sink_data_out); end
        checks++; if (dst_beat_cnt_out !== 32'd0 || ntr_beat_cnt_out !== 32'd0) begin
            errors++; $display("FAIL rst_cnt: got %0h/%0h exp 0/0", dst_beat_cnt_out, ntr_beat_cnt_out); end
        reset = 1'b0;
        checks++; if (tr_gnt_out !== 1'b0) begin errors++; $display("FAIL rst_gnt_pre_alive: got %0b exp 0", tr_gnt_out); end
        tick();
        checks++; if (tr_gnt_out !== 1'b1) begin errors++; $display("FAIL rst_gnt_alive: got %0b exp 1", tr_gnt_out); end
    endtask

    task automatic test_stream();
        sink_rdy_in = 1'b1;
        tr_vld_in = 1'b1; tr_src_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tr_data_in = W'(100 + i);
            tick();
            checks++; if (sink_vld_out !== 1'b1 || sink_data_out !== W'(100 + i) || sink_src_out !== 1'b0) begin
                errors++; $display("FAIL stream_beat%0d: got vld %0b src %0b data %0h exp 1 0 %0h", i, sink_vld_out, sink_src_out, sink_data_out, 100 + i); end
        end
        tr_vld_in = 1'b0;
        tick();
        checks++; if (sink_vld_out !== 1'b0) begin errors++; $display("FAIL stream_empty: got %0b exp 0", sink_vld_out); end
        checks++; if (dst_beat_cnt_out !== 32'd5 || ntr_beat_cnt_out !== 32'd0) begin
            errors++; $display("FAIL stream_cnt: got %0d/%0d exp 5/0", dst_beat_cnt_out, ntr_beat_cnt_out); end
    endtask

    task automatic test_backpressure();
        sink_rdy_in = 1'b0;
        tr_vld_in = 1'b1; tr_src_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tr_data_in = W'(200 + i);
            tick();
            checks++; if (dst_bp_out !== (i + 1 >= 6) || ntr_bp_out !== (i + 1 >= 6)) begin
                errors++; $display("FAIL bp_fill%0d: got %0b/%0b exp %0b", i + 1, dst_bp_out, ntr_bp_out, (i + 1 >= 6)); end
        end
        checks++; if (tr_gnt_out !== 1'b0) begin errors++; $display("FAIL bp_full_gnt: got %0b exp 0", tr_gnt_out); end
        tr_data_in = W'(299);
        tick(); tick();
        checks++; if (tr_gnt_out !== 1'b0 || sink_data_out !== W'(200)) begin
            errors++; $display("FAIL bp_hold: got gnt %0b head %0h exp 0 c8", tr_gnt_out, sink_data_out); end
        checks++; if (ntr_beat_cnt_out !== 32'd8) begin errors++; $display("FAIL bp_ntr_cnt: got %0d exp 8", ntr_beat_cnt_out); end
        tr_vld_in = 1'b0;
        sink_rdy_in = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checks++; if (sink_vld_out !== 1'b1 || sink_data_out !== W'(200 + j) || sink_src_out !== 1'b1) begin
                errors++; $display("FAIL bp_drain%0d: got vld %0b src %0b data %0h exp 1 1 %0h", j, sink_vld_out, sink_src_out, sink_data_out, 200 + j); end
            tick();
            checks++; if (dst_bp_out !== (7 - j >= 6)) begin
                errors++; $display("FAIL bp_release%0d: got %0b exp %0b", j, dst_bp_out, (7 - j >= 6)); end
        end
        checks++; if (sink_vld_out !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b exp 0", sink_vld_out); end
    endtask

    task automatic test_flush();
        sink_rdy_in = 1'b0;
        sw_flush_req_in = 1'b1;
        tick();
        sw_flush_req_in = 1'b0;
        checks++; if (dst_flush_out !== 1'b1 || ntr_flush_out !== 1'b1 || dst_bp_out !== 1'b0) begin
            errors++; $display("FAIL flush_enter: got flush %0b/%0b bp %0b exp 1/1 0", dst_flush_out, ntr_flush_out, dst_bp_out); end
        repeat (3) tick();
        tr_vld_in = 1'b1; tr_src_in = 1'b0; tr_data_in = W'(300);
        tick();
        tr_vld_in = 1'b0;
        repeat (7) tick();
        tr_vld_in = 1'b1; tr_data_in = W'(301);
        tick();
        tr_vld_in = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++; if (dst_flush_out !== 1'b1 || ntr_flush_out !== 1'b1) begin
                errors++; $display("FAIL flush_quiet%0d: got %0b/%0b exp 1/1", k, dst_flush_out, ntr_flush_out); end
        end
        tick();
        checks++; if (dst_flush_out !== 1'b0 || ntr_flush_out !== 1'b0 || sw_flush_done_out !== 1'b0) begin
            errors++; $display("FAIL flush_drain_enter: got flush %0b/%0b done %0b exp 0/0 0", dst_flush_out, ntr_flush_out, sw_flush_done_out); end
        sw_flush_req_in = 1'b1;
        tick();
        sw_flush_req_in = 1'b0;
        checks++; if (sw_flush_done_out !== 1'b0 || dst_flush_out !== 1'b0) begin
            errors++; $display("FAIL flush_drain_wait: got done %0b flush %0b exp 0 0", sw_flush_done_out, dst_flush_out); end
        sink_rdy_in = 1'b1;
        checks++; if (sink_data_out !== W'(300)) begin errors++; $display("FAIL flush_head0: got %0h exp 12c", sink_data_out); end
        tick();
        checks++; if (sink_data_out !== W'(301) || sw_flush_done_out !== 1'b0) begin
            errors++; $display("FAIL flush_head1: got data %0h done %0b exp 12d 0", sink_data_out, sw_flush_done_out); end
        tick();
        checks++; if (sink_vld_out !== 1'b0 || sw_flush_done_out !== 1'b1) begin
            errors++; $display("FAIL flush_done: got vld %0b done %0b exp 0 1", sink_vld_out, sw_flush_done_out); end
        tick();
        checks++; if (sw_flush_done_out !== 1'b0 || dst_flush_out !== 1'b0) begin
            errors++; $display("FAIL flush_done_pulse: got done %0b flush %0b exp 0 0", sw_flush_done_out, dst_flush_out); end
        checks++; if (dst_beat_cnt_out !== 32'd7) begin errors++; $display("FAIL flush_cnt: got %0d exp 7", dst_beat_cnt_out); end
    endtask

    task automatic test_stop();
        sink_rdy_in = 1'b0;
        sw_flush_req_in = 1'b1;
        tick();
        sw_flush_req_in = 1'b0;
        tr_src_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tr_vld_in = 1'b1; tr_data_in = W'(400 + i);
            tick();
        end
        tr_vld_in = 1'b0;
        checks++; if (dst_flush_out !== 1'b1 || dst_bp_out !== 1'b0) begin
            errors++; $display("FAIL stop_pre: got flush %0b bp %0b exp 1 0", dst_flush_out, dst_bp_out); end
        sink_enable_in = 1'b0;
        tick();
        checks++; if ({dst_flush_out, ntr_flush_out, dst_bp_out, ntr_bp_out} !== 4'b1111 || tr_gnt_out !== 1'b0) begin
            errors++; $display("FAIL stop_enter: got flush/bp %b gnt %0b exp 1111 0", {dst_flush_out, ntr_flush_out, dst_bp_out, ntr_bp_out}, tr_gnt_out); end
        tr_vld_in = 1'b1; tr_data_in = W'(499);
        tick();
        checks++; if (tr_gnt_out !== 1'b0 || dst_beat_cnt_out !== 32'd11) begin
            errors++; $display("FAIL stop_no_accept: got gnt %0b cnt %0d exp 0 11", tr_gnt_out, dst_beat_cnt_out); end
        sink_rdy_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (sink_vld_out !== 1'b1 || sink_data_out !== W'(400 + j) || sw_flush_done_out !== 1'b0) begin
                errors++; $display("FAIL stop_drain%0d: got vld %0b data %0h done %0b exp 1 %0h 0", j, sink_vld_out, sink_data_out, sw_flush_done_out, 400 + j); end
            tick();
        end
        tr_vld_in = 1'b0;
        checks++; if (sink_vld_out !== 1'b0 || dst_bp_out !== 1'b1 || sw_flush_done_out !== 1'b0) begin
            errors++; $display("FAIL stop_drained: got vld %0b bp %0b done %0b exp 0 1 0", sink_vld_out, dst_bp_out, sw_flush_done_out); end
        tick();
        checks++; if (sw_flush_done_out !== 1'b0) begin errors++; $display("FAIL stop_no_done: got %0b exp 0", sw_flush_done_out); end
        sink_enable_in = 1'b1;
        tick();
        checks++; if ({dst_flush_out, ntr_flush_out, dst_bp_out, ntr_bp_out} !== 4'b0000 || tr_gnt_out !== 1'b1 || sw_flush_done_out !== 1'b0) begin
            errors++; $display("FAIL stop_exit: got flush/bp %b gnt %0b done %0b exp 0000 1 0", {dst_flush_out, ntr_flush_out, dst_bp_out, ntr_bp_out}, tr_gnt_out, sw_flush_done_out); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] iv;
        sink_rdy_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iv = 32'(i);
            tr_vld_in = 1'b1; tr_src_in = iv[0]; tr_data_in = W'(500 + i);
            tick();
        end
        checks++; if (tr_gnt_out !== 1'b0) begin errors++; $display("FAIL full_gnt: got %0b exp 0", tr_gnt_out); end
        tr_src_in = 1'b0; tr_data_in = W'(508);
        sink_rdy_in = 1'b1;
        tick();
        checks++; if (sink_data_out !== W'(501) || sink_src_out !== 1'b1 || tr_gnt_out !== 1'b1) begin
            errors++; $display("FAIL full_refuse: got head %0h src %0b gnt %0b exp 1f5 1 1", sink_data_out, sink_src_out, tr_gnt_out); end
        checks++; if (dst_beat_cnt_out !== 32'd15 || ntr_beat_cnt_out !== 32'd12) begin
            errors++; $display("FAIL full_refuse_cnt: got %0d/%0d exp 15/12", dst_beat_cnt_out, ntr_beat_cnt_out); end
        tick();
        tr_vld_in = 1'b0;
        checks++; if (dst_beat_cnt_out !== 32'd16) begin errors++; $display("FAIL full_retry_cnt: got %0d exp 16", dst_beat_cnt_out); end
        for (int j = 2; j <= 8; j++) begin
            iv = 32'(j);
            checks++; if (sink_vld_out !== 1'b1 || sink_data_out !== W'(500 + j) || sink_src_out !== iv[0]) begin
                errors++; $display("FAIL full_order%0d: got vld %0b src %0b data %0h exp 1 %0b %0h", j, sink_vld_out, sink_src_out, sink_data_out, iv[0], 500 + j); end
            tick();
        end
        checks++; if (sink_vld_out !== 1'b0) begin errors++; $display("FAIL full_empty: got %0b exp 0", sink_vld_out); end
    endtask

    task automatic test_saturate_and_reset();
        sink_rdy_in = 1'b0; tr_vld_in = 1'b0;
        force dut.dst_cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.dst_cnt_q;
        #1;
        checks++; if (dst_beat_cnt_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %0h exp fffffffe", dst_beat_cnt_out); end
        tr_vld_in = 1'b1; tr_src_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tr_data_in = W'(600 + i);
            tick();
            checks++; if (dst_beat_cnt_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_beat%0d: got %0h exp ffffffff", i, dst_beat_cnt_out); end
        end
        checks++; if (sink_vld_out !== 1'b1 || sink_data_out !== W'(600)) begin
            errors++; $display("FAIL sat_queued: got vld %0b data %0h exp 1 258", sink_vld_out, sink_data_out); end
        tr_data_in = W'(603);
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({tr_gnt_out, dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out, sw_flush_done_out, sink_vld_out, sink_src_out} !== 8'b0) begin
            errors++; $display("FAIL async_rst_ctrl: got %b exp 00000000", {tr_gnt_out, dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out, sw_flush_done_out, sink_vld_out, sink_src_out}); end
        checks++; if (sink_data_out !== '0 || dst_beat_cnt_out !== 32'd0 || ntr_beat_cnt_out !== 32'd0) begin
            errors++; $display("FAIL async_rst_data: got data %0h cnt %0h/%0h exp 0 0/0", sink_data_out, dst_beat_cnt_out, ntr_beat_cnt_out); end
        tr_vld_in = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (tr_gnt_out !== 1'b1 || sink_vld_out !== 1'b0) begin
            errors++; $display("FAIL async_rst_after: got gnt %0b vld %0b exp 1 0", tr_gnt_out, sink_vld_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stop();
        test_full_push_pop();
        test_saturate_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
